// File: rtl/sys_mem_pkg.sv
// -----------------------------------------------------------------------------
// sys_mem_pkg
// Shared types and helpers for the shared-memory arbiter subsystem.
//   state_e      : arbiter FSM states (IDLE, ACCESS, RESP)
//   mem_req_t    : one requester's command (write flag, address, data, enables),
//                  sized for the system word width SYS_XLEN
//   byte_limit() : first byte address past the end of the RAM
// -----------------------------------------------------------------------------
package sys_mem_pkg;

  localparam int unsigned SYS_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [SYS_XLEN-1:0]     addr;
    logic [SYS_XLEN-1:0]     wdata;
    logic [SYS_XLEN/8-1:0]   be;
  } mem_req_t;

  // Byte-address limit of a RAM of depth words, xlen bits each.
  function automatic logic [63:0] byte_limit(input int unsigned depth, input int unsigned xlen);
    return 64'(depth) * 64'(xlen / 32'd8);
  endfunction

endpackage

// File: rtl/sys_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// sys_mem_arbiter_if
// Request/response bundle between NUM_PORTS requesters and the arbiter.
//   req_valid/req_ready/req_write : per-port request handshake and direction
//   req_addr/req_wdata/req_be     : per-port byte address, write data, enables
//   rsp_valid/rsp_ready           : per-port response handshake
//   rsp_data/rsp_exception        : shared response payload
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface sys_mem_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS-1:0]                 req_ready;
  logic [NUM_PORTS-1:0]                 req_write;
  logic [NUM_PORTS-1:0][XLEN-1:0]       req_addr;
  logic [NUM_PORTS-1:0][XLEN-1:0]       req_wdata;
  logic [NUM_PORTS-1:0][XLEN/8-1:0]     req_be;
  logic [NUM_PORTS-1:0]                 rsp_valid;
  logic [NUM_PORTS-1:0]                 rsp_ready;
  logic [XLEN-1:0]                      rsp_data;
  logic                                 rsp_exception;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_exception
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_exception
  );
endinterface

// File: rtl/sys_mem_ram.sv
// -----------------------------------------------------------------------------
// sys_mem_ram
// Single-port byte-enabled word RAM with synchronous write and an RD_LAT-stage
// read pipeline: a read launched on edge T is presented on o_rdata after edge
// T+RD_LAT-1, so the owner can capture it on edge T+RD_LAT.
//   i_clk, i_rst_n : clock, async active-low reset (pipeline only, not array)
//   i_we, i_re     : write strobe / read launch
//   i_idx          : word index
//   i_wdata, i_be  : write data and byte enables
//   o_rdata        : pipelined read data
// -----------------------------------------------------------------------------
module sys_mem_ram #(
  parameter  int XLEN   = 32,
  parameter  int DEPTH  = 1024,
  parameter  int RD_LAT = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_idx,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN/8-1:0] i_be,
  output logic [XLEN-1:0]   o_rdata
);

  logic [XLEN-1:0] r_mem     [DEPTH];
  logic [XLEN-1:0] r_rd_pipe [RD_LAT];

  // Byte-lane write; the array itself is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < XLEN / 8; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read launch plus delay stages; later stages shift every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        r_rd_pipe[k] <= '0;
      end
    end else begin
      if (i_re) begin
        r_rd_pipe[0] <= r_mem[i_idx];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        r_rd_pipe[k] <= r_rd_pipe[k-1];
      end
    end
  end

  assign o_rdata = r_rd_pipe[RD_LAT-1];

endmodule

// File: rtl/sys_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sys_mem_arbiter
// Round-robin arbiter of NUM_PORTS request channels onto one sys_mem_ram.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : sys_mem_arbiter_if.slave (request/response channels)
// Optional feature macro: SYS_MEM_ARB_RANGE_CHECK_EN
//   defined   -> addresses at/above the RAM size fault (no write, data 0)
//   undefined -> upper address bits ignored, address wraps, no faults
// The request struct is sized by SYS_XLEN; XLEN must equal SYS_XLEN.
// -----------------------------------------------------------------------------
module sys_mem_arbiter
  import sys_mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter int NUM_PORTS = 3,
  parameter int RD_LAT    = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sys_mem_arbiter_if.slave  io_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e                r_state;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         r_port;
  logic [LW-1:0]         r_lat_cnt;
  logic                  r_write;
  logic                  r_oor;
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic [XLEN-1:0]       r_rsp_data;
  logic                  r_rsp_exc;

  logic                  w_grant_found;
  logic [PW-1:0]         w_grant_idx;
  logic [PW-1:0]         w_cand;
  logic                  w_hit;
  logic                  w_accept;
  logic [NUM_PORTS-1:0]  w_req_ready;
  mem_req_t              w_g_req;
  logic                  w_g_oor;
  logic [XLEN-1:0]       w_rdata;
  logic                  w_unused_addr_bits;

  // Round-robin search: first valid port at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    w_hit         = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand        = PW'((int'(r_rr_ptr) + i) % NUM_PORTS);
      w_hit         = ~w_grant_found & io_bus.req_valid[w_cand];
      w_grant_idx   = w_hit ? w_cand : w_grant_idx;
      w_grant_found = w_grant_found | w_hit;
    end
  end

  assign w_accept = (r_state == IDLE) && w_grant_found;

  // Ready is one-hot to the granted port, and only while idle.
  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  // Command of the granted port, used directly on the accept edge.
  always_comb begin
    w_g_req.write = io_bus.req_write[w_grant_idx];
    w_g_req.addr  = io_bus.req_addr[w_grant_idx];
    w_g_req.wdata = io_bus.req_wdata[w_grant_idx];
    w_g_req.be    = io_bus.req_be[w_grant_idx];
  end

`ifdef SYS_MEM_ARB_RANGE_CHECK_EN
  assign w_g_oor = (64'(w_g_req.addr) >= byte_limit(DEPTH, XLEN));
`else
  assign w_g_oor = 1'b0;
`endif

  // Byte-offset bits (and, without range check, the high bits) are don't-care.
  assign w_unused_addr_bits = ^{w_g_req.addr[1:0], w_g_req.addr[SYS_XLEN-1:AW+2]};

  sys_mem_ram #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_accept & w_g_req.write & ~w_g_oor),
    .i_re    (w_accept & ~w_g_req.write & ~w_g_oor),
    .i_idx   (w_g_req.addr[AW+1:2]),
    .i_wdata (w_g_req.wdata),
    .i_be    (w_g_req.be),
    .o_rdata (w_rdata)
  );

  // Arbiter FSM with registered response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_port      <= '0;
      r_lat_cnt   <= '0;
      r_write     <= 1'b0;
      r_oor       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_exc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_port    <= w_grant_idx;
            r_write   <= w_g_req.write;
            r_oor     <= w_g_oor;
            r_lat_cnt <= LW'(RD_LAT - 1);
            r_rr_ptr  <= (w_grant_idx == PW'(NUM_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_lat_cnt == '0) begin
            r_rsp_valid[r_port] <= 1'b1;
            r_rsp_data          <= (r_write || r_oor) ? '0 : w_rdata;
            r_rsp_exc           <= r_oor;
            r_state             <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        RESP: begin
          // Only the owning port's ready completes the response.
          if (io_bus.rsp_ready[r_port]) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_exc   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.req_ready     = w_req_ready;
  assign io_bus.rsp_valid     = r_rsp_valid;
  assign io_bus.rsp_data      = r_rsp_data;
  assign io_bus.rsp_exception = r_rsp_exc;

endmodule

// File: doc/sys_mem_arbiter.md
# sys_mem_arbiter

Parametrised shared-memory subsystem for the system model. It arbitrates NUM_PORTS processor-side request channels (fetch, load, store, …) onto one single-port, byte-enabled RAM of DEPTH words, with configurable read latency and a valid/ready response handshake. It replaces the fixed three-port, zero-latency memory hookup in the system wrapper.

## Interface
- XLEN, 32: data and address width in bits; a multiple of 8.
- DEPTH, 1024: RAM size in XLEN-bit words; a power of two.
- NUM_PORTS, 3: number of requester channels; range 1..8.
- RD_LAT, 1: RAM access latency in cycles; range 1..4.
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accept; at most one bit set.
- req_write  in  NUM_PORTS  per-port: 1 = write, 0 = read.
- req_addr  in  NUM_PORTS×XLEN  byte address; addr[1:0] ignored (word access).
- req_wdata  in  NUM_PORTS×XLEN  write data.
- req_be  in  NUM_PORTS×XLEN/8  write byte enables; ignored for reads.
- rsp_valid  out  NUM_PORTS  response valid, one-hot to the owning port.
- rsp_ready  in  NUM_PORTS  per-port response accept.
- rsp_data  out  XLEN  read data; 0 for writes and exceptions.
- rsp_exception  out  1  access fault for the current response.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: round-robin grant among req_valid, starting at rr_ptr. req_ready[g] = 1 only for the granted port g. On req_valid[g] && req_ready[g], latch port id, write flag, address, data and byte enables. Go to ACCESS and load lat_cnt = RD_LAT-1. Set rr_ptr = (g+1) mod NUM_PORTS.
- Write: RAM bytes with be=1 update on the accept edge; bytes with be=0 are unchanged.
- ACCESS: lat_cnt decrements each cycle. At 0, capture read data (writes: 0) and go to RESP.
- RESP: rsp_valid[port] = 1, with rsp_data and rsp_exception stable until rsp_ready[port]. On the handshake, go to IDLE.
- Word index = addr[$clog2(DEPTH)+1:2]. Upper address bits are handled per Configuration.
- No request is accepted outside IDLE; all req_ready are 0 in ACCESS and RESP.
- Reset, including mid-transaction: state IDLE, rr_ptr 0, lat_cnt 0. All req_ready, rsp_valid, rsp_data and rsp_exception are 0. The in-flight transaction is dropped, and a write already committed stays written. RAM contents are not reset.

## Timing
- Request accepted on edge T. rsp_valid rises after edge T+RD_LAT and holds until the rsp_ready handshake edge.
- req_ready is combinational from req_valid and rr_ptr, valid only in IDLE. A requester must hold valid, addr and data until it sees ready.
- Minimum spacing between accepts: RD_LAT+2 cycles (accept, RD_LAT-1 ACCESS cycles, ≥1 RESP cycle, IDLE).
- Simultaneous requests: the lowest index ≥ rr_ptr wins, wrapping modulo NUM_PORTS. No port waits more than NUM_PORTS-1 grants.
- rsp_ready asserted early or to a non-owning port is ignored.

## Configuration
- SYS_MEM_ARB_RANGE_CHECK_EN defined: address ≥ DEPTH*XLEN/8 gives rsp_exception = 1 and rsp_data = 0. No RAM write occurs, and the FSM latency is unchanged.
- Macro undefined: upper address bits are ignored, the address wraps modulo DEPTH words, and rsp_exception is tied to 0.

## Structure
- Package sys_mem_pkg:
  - state enum (IDLE, ACCESS, RESP);
  - packed request struct (write, addr, wdata, be);
  - helper constant for the byte-address limit.
- Sub-module sys_mem_ram: single-port, byte-enabled word array with a synchronous write and an RD_LAT-stage read pipeline.
- The arbiter and FSM live in sys_mem_arbiter.

## Test plan
- Reset mid-ACCESS, then release: all outputs 0, rr_ptr 0. A subsequent read of an address written before reset returns the committed value.
- Port 1 writes 0xDEADBEEF to 0x10 with be=4'b1111. Port 1 then writes 0x000000AA with be=4'b0001. Port 0 reads 0x10 → rsp_data = 0xDEADBEAA. With RD_LAT=3, rsp_valid rises 3 cycles after the accept.
- Ports 0, 1 and 2 hold req_valid continuously with rr_ptr=0 → grant order is 0, 1, 2, 0. No port is starved.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_data stay stable and all req_ready stay 0. On rsp_ready=1 the next grant follows 1 cycle later.
- Range-check enabled, DEPTH=1024: read 0x1000 → rsp_exception=1, rsp_data=0. Write to 0x1000 leaves word 0 unchanged.
- Range-check disabled: write 0x55 to 0x1000, read 0x0 → rsp_data = 0x55 (wrap), rsp_exception=0.
